// File: rtl/hdmi_packet_scheduler.sv
// Data-island packet scheduler: picks ACR / audio / AVI / audio InfoFrame / null per packet slot.
// Optional HDMI_PACKET_SCHED_STATS_EN adds acr_sent_cnt and null_sent_cnt pick counters.
module hdmi_packet_scheduler #(
  parameter int INFOFRAME_PERIOD = 1,
  parameter int ACR_PENDING_MAX  = 3
) (
  input  logic         clk_pixel,
  input  logic         rst_n,
  input  logic         packet_slot,
  input  logic         frame_end,
  input  logic         clk_audio_counter_wrap,
  input  logic [23:0]  acr_header,
  input  logic [223:0] acr_sub,
  input  logic         aud_valid,
  output logic         aud_ready,
  input  logic [23:0]  aud_header,
  input  logic [223:0] aud_sub,
  input  logic [23:0]  avi_header,
  input  logic [223:0] avi_sub,
  input  logic [23:0]  ai_header,
  input  logic [223:0] ai_sub,
  output logic [23:0]  header,
  output logic [223:0] sub,
  output logic [2:0]   packet_type,
  output logic         acr_overflow
`ifdef HDMI_PACKET_SCHED_STATS_EN
  ,
  output logic [15:0]  acr_sent_cnt,
  output logic [15:0]  null_sent_cnt
`endif
);

  localparam logic [2:0] PT_NULL = 3'd0;
  localparam logic [2:0] PT_ACR  = 3'd1;
  localparam logic [2:0] PT_AUD  = 3'd2;
  localparam logic [2:0] PT_AVI  = 3'd3;
  localparam logic [2:0] PT_AI   = 3'd4;
  localparam logic [1:0] ACR_MAX_C = 2'(ACR_PENDING_MAX);
  localparam logic [7:0] IF_LAST_C = 8'(INFOFRAME_PERIOD - 1);

  logic         wrap_q_r;
  logic [1:0]   acr_pend_r;
  logic         avi_pend_r;
  logic         ai_pend_r;
  logic [7:0]   frame_cnt_r;
  logic [23:0]  header_r;
  logic [223:0] sub_r;
  logic [2:0]   type_r;
  logic         aud_ready_r;
  logic         acr_overflow_r;

  logic         acr_req_s;
  logic         pick_acr_s;
  logic         if_set_s;
  logic [2:0]   sel_type_s;
  logic [23:0]  sel_header_s;
  logic [223:0] sel_sub_s;

  assign acr_req_s  = wrap_q_r ^ clk_audio_counter_wrap;
  assign pick_acr_s = packet_slot && (sel_type_s == PT_ACR);
  assign if_set_s   = frame_end && (frame_cnt_r == IF_LAST_C);

  // Fixed-priority packet choice for the current slot.
  always_comb begin
    sel_type_s = PT_NULL;
    if (acr_pend_r != 2'd0) begin
      sel_type_s = PT_ACR;
    end else if (aud_valid) begin
      sel_type_s = PT_AUD;
    end else if (avi_pend_r) begin
      sel_type_s = PT_AVI;
    end else if (ai_pend_r) begin
      sel_type_s = PT_AI;
    end else begin
      sel_type_s = PT_NULL;
    end
  end

  // Payload mux for the chosen packet type.
  always_comb begin
    sel_header_s = 24'h000000;
    sel_sub_s    = '0;
    case (sel_type_s)
      PT_ACR:  begin sel_header_s = acr_header; sel_sub_s = acr_sub; end
      PT_AUD:  begin sel_header_s = aud_header; sel_sub_s = aud_sub; end
      PT_AVI:  begin sel_header_s = avi_header; sel_sub_s = avi_sub; end
      PT_AI:   begin sel_header_s = ai_header;  sel_sub_s = ai_sub;  end
      default: begin sel_header_s = 24'h000000; sel_sub_s = '0;      end
    endcase
  end

  // ACR request edge detect and saturating pending counter.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q_r       <= 1'b0;
      acr_pend_r     <= 2'd0;
      acr_overflow_r <= 1'b0;
    end else begin
      wrap_q_r <= clk_audio_counter_wrap;
      case ({acr_req_s, pick_acr_s})
        2'b10: begin
          if (acr_pend_r == ACR_MAX_C) acr_overflow_r <= 1'b1;
          else                         acr_pend_r     <= acr_pend_r + 2'd1;
        end
        2'b01:   acr_pend_r <= acr_pend_r - 2'd1;
        default: acr_pend_r <= acr_pend_r;
      endcase
    end
  end

  // Frame counter; a wrap re-arms both InfoFrames, and that set beats a same-cycle pick.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r <= 8'd0;
      avi_pend_r  <= 1'b1;
      ai_pend_r   <= 1'b1;
    end else begin
      if (frame_end) begin
        frame_cnt_r <= if_set_s ? 8'd0 : frame_cnt_r + 8'd1;
      end
      if (if_set_s) begin
        avi_pend_r <= 1'b1;
        ai_pend_r  <= 1'b1;
      end else begin
        if (packet_slot && (sel_type_s == PT_AVI)) avi_pend_r <= 1'b0;
        if (packet_slot && (sel_type_s == PT_AI))  ai_pend_r  <= 1'b0;
      end
    end
  end

  // Registered packet outputs, held between slots; aud_ready pulses after an audio pick.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      header_r    <= 24'h000000;
      sub_r       <= '0;
      type_r      <= PT_NULL;
      aud_ready_r <= 1'b0;
    end else begin
      aud_ready_r <= packet_slot && (sel_type_s == PT_AUD);
      if (packet_slot) begin
        header_r <= sel_header_s;
        sub_r    <= sel_sub_s;
        type_r   <= sel_type_s;
      end
    end
  end

`ifdef HDMI_PACKET_SCHED_STATS_EN
  logic [15:0] acr_sent_r;
  logic [15:0] null_sent_r;

  // Wrapping pick statistics.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      acr_sent_r  <= 16'd0;
      null_sent_r <= 16'd0;
    end else begin
      if (pick_acr_s) acr_sent_r <= acr_sent_r + 16'd1;
      if (packet_slot && (sel_type_s == PT_NULL)) null_sent_r <= null_sent_r + 16'd1;
    end
  end

  assign acr_sent_cnt  = acr_sent_r;
  assign null_sent_cnt = null_sent_r;
`endif

  assign header       = header_r;
  assign sub          = sub_r;
  assign packet_type  = type_r;
  assign aud_ready    = aud_ready_r;
  assign acr_overflow = acr_overflow_r;

endmodule

// File: doc/hdmi_packet_scheduler.md
Name: hdmi_packet_scheduler

Overview:
- Downstream of the audio clock regeneration (ACR) packet generator, in the clk_pixel domain.
- Per data-island packet slot, picks one packet among: ACR, audio sample, AVI InfoFrame, audio InfoFrame, null.
- Presents the picked packet's 24-bit header and 224-bit subpacket bus to the data-island encoder.
- ACR is triggered by each toggle of the ACR generator's clk_audio_counter_wrap; InfoFrames are sent once per INFOFRAME_PERIOD frames.

Parameters:
- INFOFRAME_PERIOD, 1, frames between InfoFrame transmissions (1..255).
- ACR_PENDING_MAX, 3, maximum queued ACR requests; saturating.

Ports:
- clk_pixel  in  1  pixel clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- packet_slot  in  1  one-cycle pulse: the next packet slot starts; latch a selection.
- frame_end  in  1  one-cycle pulse at end of each video frame.
- clk_audio_counter_wrap  in  1  toggle from ACR generator; each edge = one ACR request.
- acr_header  in  24  ACR header.
- acr_sub  in  224  ACR subpackets.
- aud_valid  in  1  audio sample packet available.
- aud_ready  out  1  one-cycle pulse: audio sample packet consumed.
- aud_header  in  24
- aud_sub  in  224
- avi_header  in  24
- avi_sub  in  224
- ai_header  in  24  audio InfoFrame header.
- ai_sub  in  224
- header  out  24  selected header, registered.
- sub  out  224  selected subpackets, registered.
- packet_type  out  3  0 null, 1 ACR, 2 audio, 3 AVI, 4 audio InfoFrame.
- acr_overflow  out  1  sticky; set when an ACR request is dropped.

Behaviour:
- Reset (async, rst_n low): header=0, sub=0, packet_type=0, aud_ready=0, acr_overflow=0, acr_pend=0, avi_pend=1, ai_pend=1, frame counter=0, wrap_q=0.
- ACR request detect: wrap_q <= clk_audio_counter_wrap; request = wrap_q ^ clk_audio_counter_wrap.
  - Input is already synchronous to clk_pixel; no synchroniser.
- acr_pend: 2-bit counter, 0..ACR_PENDING_MAX.
  - +1 per request, -1 per ACR pick; request and pick in the same cycle leave it unchanged.
  - Request at ACR_PENDING_MAX with no pick: count stays, acr_overflow <= 1. Cleared only by reset.
- Frame counter: counts frame_end pulses.
  - On reaching INFOFRAME_PERIOD-1 with frame_end: wrap to 0 and set avi_pend=1, ai_pend=1.
  - If a set coincides with a clear by a pick, set wins.
- Selection on packet_slot=1, fixed priority:
  - ACR if acr_pend>0.
  - else audio if aud_valid.
  - else AVI if avi_pend.
  - else audio InfoFrame if ai_pend.
  - else null.
- Latency: header, sub and packet_type update on the clock edge that samples packet_slot; valid from the next cycle. They hold until the next packet_slot.
  - Pick uses input bus values sampled on that same edge.
- aud_ready pulses high for the one cycle following an audio pick. The upstream source must hold aud_* stable while aud_valid=1 until it sees aud_ready.
- Null packet: header=24'h000000, sub=0.
- packet_slot pulses closer than 2 cycles apart are illegal; behaviour is unspecified.
- frame_end and packet_slot may coincide: the pend update and the pick are evaluated independently; set-wins rule applies.

Optional Feature:
- Macro: HDMI_PACKET_SCHED_STATS_EN.
- Defined: adds output acr_sent_cnt (16-bit) and output null_sent_cnt (16-bit).
  - Each increments on the corresponding pick and wraps at 16'hFFFF->0.
  - Both reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then packet_slot with no requests, aud_valid=0 -> packet_type=3 (AVI); next slot ->4; next slot ->0 with header=0, sub=0.
- One toggle of clk_audio_counter_wrap, aud_valid=1, then packet_slot -> packet_type=1, header=acr_header, aud_ready=0; next slot -> packet_type=2, aud_ready pulses exactly 1 cycle.
- Five wrap toggles, no slots -> acr_overflow=1; then four slots -> packet_type sequence 1,1,1,then not 1.
- Wrap toggle on the same cycle as a slot that picks ACR with acr_pend=1 -> acr_pend stays 1; next slot picks ACR again.
- INFOFRAME_PERIOD=2: after reset-time InfoFrames drain, one frame_end -> no InfoFrame picked; second frame_end -> AVI then audio InfoFrame on the next two idle slots.
- rst_n asserted low mid-frame with acr_pend=2 -> outputs 0 immediately (asynchronously); after release, first slot picks AVI, not ACR.
